// File: rtl/booth_mult_seq_pkg.sv
// booth_pkg: shared types and helpers for the sequential Booth multiplier.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   op_t          : Booth recode operation (NOP, +M, -M, +2M, -2M)
//   RADIX4        : 1 when BOOTH_RADIX4_EN is defined (radix-4 build)
//   booth_iters   : Booth steps per operation for a given width/radix
//   booth_latency : rising edges from accepting edge to out_valid
// Configuration macro: BOOTH_RADIX4_EN selects radix-4 modified Booth.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_SUB, OP_ADD2, OP_SUB2} op_t;

`ifdef BOOTH_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif

  function automatic int booth_iters(int width, bit radix4);
    return radix4 ? (width / 2 + 1) : (width + 1);
  endfunction

  // The radix-4 build spends one extra cycle after its last step so the
  // wider +/-2M adder output is registered before it reaches out_p.
  function automatic int booth_latency(int width, bit radix4);
    return radix4 ? (booth_iters(width, radix4) + 1) : booth_iters(width, radix4);
  endfunction

  // Radix-2 recode on {q0, q_-1}.
  function automatic op_t booth_recode2(logic [1:0] pair);
    case (pair)
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

`ifdef BOOTH_RADIX4_EN
  // Radix-4 modified Booth recode on {q1, q0, q_-1}.
  function automatic op_t booth_recode4(logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: return OP_ADD;
      3'b011:         return OP_ADD2;
      3'b100:         return OP_SUB2;
      3'b101, 3'b110: return OP_SUB;
      default:        return OP_NOP;
    endcase
  endfunction
`endif

endpackage

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: operand/result handshake bundle for booth_mult_seq.
//   in_valid/in_ready/in_signed/in_a/in_b : operand channel
//   out_valid/out_ready/out_p             : product channel
//   busy                                  : multiplier is in RUN or DONE
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data stable until that edge; the
// consumer may drive ready freely. out_valid/out_p stay stable until taken.
interface booth_mult_seq_if #(parameter int WIDTH = 16);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/booth_mult_seq_addsub.sv
// booth_addsub: W-bit modulo adder/subtractor for the accumulator update.
//   a, b : operands
//   add  : 1 = a + b, 0 = a - b
//   y    : result modulo 2^W
module booth_addsub #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         add,
  output logic [W-1:0] y
);
  assign y = add ? (a + b) : (a - b);
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier, one Booth step per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : booth_mult_seq_if slave (operand and product handshakes)
//   dbg_state  : current FSM state
// Default build is radix-2 (WIDTH+1 steps, 17-edge latency at WIDTH=16).
// Defining BOOTH_RADIX4_EN selects radix-4 modified Booth (WIDTH/2+1 steps).
// Operands are extended by one (radix-4: two) bits so that signed and
// unsigned inputs both become non-overflowing signed values; the low
// 2*WIDTH bits of the result are then exact in either mode.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mult_seq_if.slave   bus,
  output state_t            dbg_state
);

  localparam int ITERS  = booth_iters(WIDTH, RADIX4);
  localparam int LAT    = booth_latency(WIDTH, RADIX4);
  localparam int SH     = RADIX4 ? 2 : 1;
  localparam int EXT_W  = WIDTH + SH;
  localparam int ACC_W  = RADIX4 ? (WIDTH + 4) : (WIDTH + 2);
  localparam int CNT_W  = $clog2(LAT + 1);
  localparam int FULL_W = ACC_W + EXT_W + 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  logic [EXT_W-1:0]     q;
  logic                 q_m1;
  logic [EXT_W-1:0]     m;
  logic                 out_valid_r;
  logic [2*WIDTH-1:0]   out_p_r;

  logic [ACC_W-1:0]       m_acc;
  logic [ACC_W-1:0]       addend;
  logic [ACC_W-1:0]       sum;
  logic [ACC_W-1:0]       acc_next;
  logic                   add_sel;
  op_t                    op;
  logic [FULL_W-1:0]      sh_full;
  logic [ACC_W+EXT_W-1:0] prod_next;
  logic                   step_do;

  function automatic logic [EXT_W-1:0] ext_op(logic [WIDTH-1:0] v, logic sgn);
    return {{SH{sgn & v[WIDTH-1]}}, v};
  endfunction

  always_comb begin
    m_acc = {{(ACC_W-EXT_W){m[EXT_W-1]}}, m};
`ifdef BOOTH_RADIX4_EN
    op      = booth_recode4({q[1], q[0], q_m1});
    addend  = ((op == OP_ADD2) || (op == OP_SUB2)) ? {m_acc[ACC_W-2:0], 1'b0} : m_acc;
    add_sel = (op == OP_ADD) || (op == OP_ADD2);
`else
    op      = booth_recode2({q[0], q_m1});
    addend  = m_acc;
    add_sel = (op == OP_ADD);
`endif
    acc_next  = (op == OP_NOP) ? acc : sum;
    sh_full   = $signed({acc_next, q, q_m1}) >>> SH;
    step_do   = (cnt < CNT_W'(ITERS));
    // Product as it will stand after this edge: post-step on a step edge,
    // otherwise the already-final {acc, q}.
    prod_next = step_do ? sh_full[FULL_W-1:1] : {acc, q};
  end

  booth_addsub #(.W(ACC_W)) u_addsub (
    .a   (acc),
    .b   (addend),
    .add (add_sel),
    .y   (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
      m           <= '0;
      out_valid_r <= 1'b0;
      out_p_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m     <= ext_op(bus.in_a, bus.in_signed);
            q     <= ext_op(bus.in_b, bus.in_signed);
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (step_do) begin
            {acc, q, q_m1} <= sh_full;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(LAT - 1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            out_p_r     <= (2*WIDTH)'(prod_next);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_p     = out_p_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: self-checking bench for booth_mult_seq (WIDTH=16).
// Expected products come from a 64-bit integer reference multiply and are
// queued at accept time, then popped when out_valid is observed.
module tb_booth_mult_seq;
  import booth_pkg::*;

  localparam int W = 16;
`ifdef BOOTH_RADIX4_EN
  localparam int EXP_LAT = 10;
`else
  localparam int EXP_LAT = 17;
`endif
  localparam int N_RANDOM = 1500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(W)) bus();
  state_t dbg_state;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic s);
    longint pa, pb, p;
    logic [63:0] pv;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: in_ready=%b, required 1", bus.in_ready);
    end
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_valid  = 1'b1;
    exp_q.push_back(ref_mul(a, b, s));
    @(negedge clk);
    // Scramble operands after the accepting edge; they must not matter.
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'($urandom_range(0, 65535));
    bus.in_b      = 16'($urandom_range(0, 65535));
    bus.in_signed = 1'($urandom_range(0, 1));
  endtask

  // Waits for out_valid, checks latency and product, optionally holds
  // out_ready low for 'hold' cycles while poking the input channel.
  task automatic collect(input string name, input int hold, input bit chk_busy);
    int lat;
    bit busy_bad;
    logic [2*W-1:0] exp, snap;
    lat = 0;
    busy_bad = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (chk_busy) begin
      tests_run++;
      if (busy_bad) begin
        tests_failed++;
        $display("FAIL %s_busy: busy dropped before out_valid, required 1 throughout", name);
      end
    end
    tests_run++;
    if (lat != EXP_LAT) begin
      tests_failed++;
      $display("FAIL %s_latency: %0d edges, required %0d", name, lat, EXP_LAT);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!bus.out_valid) begin
      apply_reset();
      return;
    end
    tests_run++;
    if (bus.out_p !== exp) begin
      tests_failed++;
      $display("FAIL %s_product: out_p=%h, required %h", name, bus.out_p, exp);
    end
    snap = bus.out_p;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a     = 16'($urandom_range(0, 65535));
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_p !== snap || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_hold: out_valid=%b out_p=%h in_ready=%b, required 1 %h 0",
                 name, bus.out_valid, bus.out_p, bus.in_ready, snap);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: %b, required 1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: %b, required 0", bus.out_valid);
    end
    tests_run++;
    if (bus.out_p !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_out_p: %h, required 00000000", bus.out_p);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b state=%0d, required 0 %0d", bus.busy, dbg_state, IDLE);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
    logic [W-1:0] tb[5] = '{16'hFFFB, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic         ts[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2*W-1:0] tp[5] = '{32'hFFFFFFF1, 32'hFFFE0001, 32'h00000001,
                              32'h40000000, 32'hC0008000};
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], ts[i]);
      // Hand-derived values cross-check the reference model as well.
      tests_run++;
      if (exp_q[exp_q.size()-1] !== tp[i]) begin
        tests_failed++;
        $display("FAIL directed_model_%0d: model=%h, required %h", i, exp_q[exp_q.size()-1], tp[i]);
      end
      collect($sformatf("directed_%0d", i), 0, (i == 0));
    end
  endtask

  task automatic test_backpressure();
    send(16'h1234, 16'h00AB, 1'b0);
    collect("backpressure", 5, 1'b0);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset_midop();
    bit seen;
    send(16'h1111, 16'h2222, 1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_p !== 32'h0 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL midop_reset: out_valid=%b out_p=%h in_ready=%b busy=%b, required 0 00000000 1 0",
               bus.out_valid, bus.out_p, bus.in_ready, bus.busy);
    end
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL midop_no_pulse: out_valid=1 seen, required 0");
    end
    send(16'd7, 16'd6, 1'b1);
    tests_run++;
    if (exp_q[exp_q.size()-1] !== 32'h0000002A) begin
      tests_failed++;
      $display("FAIL midop_model: model=%h, required 0000002a", exp_q[exp_q.size()-1]);
    end
    collect("midop_7x6", 0, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] corners[6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < N_RANDOM; i++) begin
      a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom_range(0, 65535));
      s = 1'($urandom_range(0, 1));
      send(a, b, s);
      collect("random", $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
